uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART byte transmitter on GPIO between several message sources: drive-state JSON, classifier reports and debug telemetry. Each source asks for the link with `req`. Once granted, it streams a whole message byte by byte with valid/ready/last, and the arbiter holds the grant until the last byte is accepted. A per-message inactivity watchdog prevents a stalled source from locking the link.

---
 rtl/uart_tx_arbiter.sv | 126 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the shared UART byte transmitter. A granted source keeps
// the link for a whole message; a per-message watchdog reclaims it from a stalled source.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 3,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   src_data,
  input  logic [NUM_REQ-1:0]          src_valid,
  input  logic [NUM_REQ-1:0]          src_last,
  output logic [NUM_REQ-1:0]          src_ready,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        busy,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        timeout_err
);

  localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int IW1 = IW + 1;
  localparam int CW  = $clog2(TIMEOUT_CYC);

  localparam logic [CW-1:0] WD_MAX   = CW'(TIMEOUT_CYC - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [IW:0]   NREQ_W   = IW1'(NUM_REQ);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_XFER    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  logic [1:0]         state;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      owner;
  logic [CW-1:0]      wd_cnt;

  logic [IW:0]        rot_sh;
  logic [IW:0]        sum;
  logic [NUM_REQ-1:0] rot;
  logic [IW-1:0]      off;
  logic [IW-1:0]      winner;
  logic [NUM_REQ-1:0] winner_oh;
  logic               xfer;
  logic               last_sel;
  logic               beat;

  // Rotate req so that bit 0 is the requester at ptr; the lowest set bit wins.
  always_comb begin
    rot_sh = NREQ_W - {1'b0, ptr};
    rot    = (req >> ptr) | (req << rot_sh);
    off    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NREQ_W) sum = sum - NREQ_W;
    winner = sum[IW-1:0];
    winner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      winner_oh[i] = (winner == IW'(i));
    end
  end

  // Byte path: grant is one-hot in XFER and zero elsewhere, so it selects directly.
  always_comb begin
    xfer    = (state == ST_XFER);
    tx_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (xfer && grant[i]) tx_data = src_data[i*DATA_W +: DATA_W];
    end
    tx_valid  = xfer & (|(src_valid & grant));
    last_sel  = |(src_last & grant);
    src_ready = (xfer && tx_ready) ? grant : '0;
    beat      = tx_valid & tx_ready;
    busy      = (state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      grant       <= '0;
      owner       <= '0;
      ptr         <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|req) begin
            state  <= ST_XFER;
            grant  <= winner_oh;
            owner  <= winner;
            wd_cnt <= '0;
          end
        end
        ST_XFER: begin
          // A beat in the expiry cycle takes priority over the abort.
          if (beat) begin
            wd_cnt <= '0;
            if (last_sel) begin
              state <= ST_RELEASE;
              grant <= '0;
            end
          end else if (wd_cnt == WD_MAX) begin
            timeout_err <= 1'b1;
            state       <= ST_RELEASE;
            grant       <= '0;
            wd_cnt      <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          state <= ST_IDLE;
          ptr   <= (owner == LAST_IDX) ? '0 : owner + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, every cycle
// compared against a message-level model of link ownership.
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int W  = 8;
  localparam int TO = 16;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req;
  logic [N*W-1:0]   src_data;
  logic [N-1:0]     src_valid;
  logic [N-1:0]     src_last;
  logic [N-1:0]     src_ready;
  logic [N-1:0]     grant;
  logic             busy;
  logic [W-1:0]     tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             timeout_err;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .src_data(src_data),
    .src_valid(src_valid), .src_last(src_last), .src_ready(src_ready),
    .grant(grant), .busy(busy), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .timeout_err(timeout_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

  int passed = 0;
  int total  = 0;
  logic [W-1:0] exp_q[$];

  // model: who owns the link, whether we are in the post-message gap
  int m_owner, m_ptr, m_quiet;
  bit m_rel, m_to;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_quiet = 0; m_rel = 0; m_to = 0;
    exp_q.delete();
  endtask

  task automatic end_msg();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_rel   = 1;
  endtask

  // Called at a negedge with inputs driven; compares, advances the model, waits a cycle.
  task automatic cycle();
    logic [N-1:0] one, e_grant, e_ready;
    logic [W-1:0] e_data;
    logic e_valid, e_beat;
    #1;
    one     = 1;
    e_grant = (m_owner >= 0) ? (one << m_owner) : '0;
    e_valid = (m_owner >= 0) && src_valid[m_owner];
    e_data  = (m_owner >= 0) ? src_data[m_owner*W +: W] : '0;
    e_ready = (m_owner >= 0 && tx_ready) ? e_grant : '0;
    e_beat  = e_valid && tx_ready;
    check("grant", grant, e_grant);
    check("busy", busy, (m_owner >= 0) || m_rel);
    check("tx_valid", tx_valid, e_valid);
    check("tx_data", tx_data, e_data);
    check("src_ready", src_ready, e_ready);
    check("timeout_err", timeout_err, m_to);
    if (e_beat) exp_q.push_back(e_data);
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) check("sb_extra_byte", 1, 0);
      else check("sb_byte", tx_data, exp_q.pop_front());
    end
    m_to = 0;
    if (m_rel) m_rel = 0;
    else if (m_owner < 0) begin
      int w;
      w = pick();
      if (w >= 0) begin m_owner = w; m_quiet = 0; end
    end else if (e_beat) begin
      m_quiet = 0;
      if (src_last[m_owner]) end_msg();
    end else if (m_quiet == TO - 1) begin
      m_to = 1;
      end_msg();
    end else m_quiet++;
    @(negedge clk);
  endtask

  // driver tasks
  task automatic set_src(input int i, input logic v, input logic [W-1:0] d, input logic l);
    src_valid[i] = v;
    src_data[i*W +: W] = d;
    src_last[i] = l;
  endtask

  task automatic idle_inputs();
    req = '0; src_valid = '0; src_last = '0; src_data = '0; tx_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_src_ready", src_ready, 0);
    check("rst_timeout", timeout_err, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] order[$];
    logic [W-1:0] got[$];
    logic [W-1:0] msg[3];
    logic [3:0]   rdy_pat;
    int n;

    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    do_reset();

    // single source, 3-byte message
    msg[0] = 8'h7B; msg[1] = 8'h22; msg[2] = 8'h7D;
    req = 3'b001;
    cycle();
    req = '0;
    for (int b = 0; b < 3; b++) begin
      set_src(0, 1'b1, msg[b], b == 2);
      #1;
      check("single_grant", grant, 3'b001);
      check("single_data", tx_data, msg[b]);
      cycle();
    end
    set_src(0, 1'b0, 8'h00, 1'b0);
    #1;
    check("single_release_grant", grant, 3'b000);
    check("single_release_busy", busy, 1);
    cycle();
    #1;
    check("single_idle_busy", busy, 0);
    cycle();

    // contention from reset, one-byte messages
    do_reset();
    req = 3'b111;
    for (int i = 0; i < N; i++) set_src(i, 1'b1, W'(8'hC0 + i), 1'b1);
    for (int c = 0; c < 12; c++) begin
      #1;
      if (grant != '0) order.push_back(grant);
      cycle();
    end
    check("rr_count", order.size(), 4);
    if (order.size() >= 4) begin
      check("rr_order0", order[0], 3'b001);
      check("rr_order1", order[1], 3'b010);
      check("rr_order2", order[2], 3'b100);
      check("rr_order3", order[3], 3'b001);
    end
    idle_inputs();
    repeat (2) cycle();

    // backpressure on a 2-byte message
    req = 3'b001;
    cycle();
    req = '0;
    rdy_pat = 4'b1001;
    for (int c = 0; c < 4; c++) begin
      if (c == 0) set_src(0, 1'b1, 8'hA5, 1'b0);
      else set_src(0, 1'b1, 8'h3C, 1'b1);
      tx_ready = rdy_pat[c];
      #1;
      check("bp_ready", src_ready, {2'b00, tx_ready});
      if (src_valid[0] && src_ready[0]) got.push_back(tx_data);
      cycle();
    end
    check("bp_count", got.size(), 2);
    if (got.size() == 2) begin
      check("bp_byte0", got[0], 8'hA5);
      check("bp_byte1", got[1], 8'h3C);
    end
    idle_inputs();
    repeat (2) cycle();

    // watchdog abort on source 1
    req = 3'b010;
    cycle();
    req = '0;
    set_src(1, 1'b1, 8'h55, 1'b0);
    #1;
    check("to_grant", grant, 3'b010);
    cycle();
    set_src(1, 1'b0, 8'h00, 1'b0);
    n = 0;
    while (n < 40) begin
      #1;
      if (timeout_err) break;
      cycle();
      n++;
    end
    check("to_delay", n, 16);
    check("to_grant_cleared", grant, 0);
    req = 3'b111;
    cycle();
    cycle();
    #1;
    check("to_next_grant", grant, 3'b100);
    req = '0;
    set_src(2, 1'b1, 8'hA1, 1'b1);
    cycle();
    idle_inputs();
    repeat (2) cycle();

    // beat on the last permissible idle cycle
    req = 3'b001;
    cycle();
    req = '0;
    set_src(0, 1'b1, 8'h11, 1'b0);
    cycle();
    set_src(0, 1'b0, 8'h00, 1'b0);
    repeat (15) cycle();
    set_src(0, 1'b1, 8'h22, 1'b0);
    #1;
    check("race_tx_valid", tx_valid, 1);
    cycle();
    set_src(0, 1'b0, 8'h00, 1'b0);
    #1;
    check("race_grant_held", grant, 3'b001);
    check("race_no_timeout", timeout_err, 0);
    set_src(0, 1'b1, 8'h33, 1'b1);
    cycle();
    idle_inputs();
    repeat (2) cycle();

    // reset in the middle of a 4-byte message
    req = 3'b001;
    cycle();
    req = '0;
    set_src(0, 1'b1, 8'h01, 1'b0);
    cycle();
    set_src(0, 1'b1, 8'h02, 1'b0);
    #1;
    check("mid_pre_grant", grant, 3'b001);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_tx_valid", tx_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_timeout", timeout_err, 0);
    model_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    req = 3'b010;
    cycle();
    #1;
    check("mid_after_grant", grant, 3'b010);
    req = '0;
    set_src(1, 1'b1, 8'h44, 1'b1);
    cycle();
    idle_inputs();
    repeat (2) cycle();

    // random traffic with periodic stalls long enough to trip the watchdog
    for (int c = 0; c < 2500; c++) begin
      req = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        set_src(i, $urandom_range(0, 9) < 7, W'($urandom_range(0, 255)),
                $urandom_range(0, 3) == 0);
      end
      if ((c % 400) >= 370) src_valid = '0;
      tx_ready = $urandom_range(0, 3) != 0;
      cycle();
    end
    idle_inputs();
    repeat (4) cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
